// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential execute-stage ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_MIN_S = 5'd5,
    OP_MIN_U = 5'd6,
    OP_SRA   = 5'd7,
    OP_SRL   = 5'd8,
    OP_SLL   = 5'd9,
    OP_MUL   = 5'd10,
    OP_LUI   = 5'd11,
    OP_EQ    = 5'd12,
    OP_NE    = 5'd13,
    OP_LT_S  = 5'd14,
    OP_GE_S  = 5'd15,
    OP_LT_U  = 5'd16,
    OP_GE_U  = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int OP_COUNT = 18;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add signed multiplier: works on magnitudes for WIDTH cycles,
// negates at the end, and returns only the low WIDTH bits of the product.
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             neg;

  // Only the low WIDTH bits are kept, which is exact modulo 2^WIDTH.
  assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
  assign done       = busy && (cnt == CW'(WIDTH - 1));
  assign product_lo = neg ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a[WIDTH-1] ? -a : a;
      mplier <= b[WIDTH-1] ? -b : b;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready on both sides; every op takes
// one cycle except MUL, which is handed to the iterative multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] l_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic [4:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state, state_nxt;
  logic             armed;
  logic             accept, is_mul;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_lo, alu_res;
  logic [SHW-1:0]   sh;

  // armed keeps in_ready low until the first edge after reset release.
  assign in_ready  = armed && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (control == OP_MUL);
  assign sh        = r_in[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (control)
      OP_ADD:   alu_res = l_in + r_in;
      OP_SUB:   alu_res = l_in - r_in;
      OP_AND:   alu_res = l_in & r_in;
      OP_OR:    alu_res = l_in | r_in;
      OP_XOR:   alu_res = l_in ^ r_in;
      OP_MIN_S: alu_res = ($signed(l_in) < $signed(r_in)) ? l_in : r_in;
      OP_MIN_U: alu_res = (l_in < r_in) ? l_in : r_in;
      OP_SRA:   alu_res = $signed(l_in) >>> sh;
      OP_SRL:   alu_res = l_in >> sh;
      OP_SLL:   alu_res = l_in << sh;
      OP_LUI:   alu_res = r_in << LUI_SHIFT;
      OP_EQ:    alu_res = WIDTH'(l_in == r_in);
      OP_NE:    alu_res = WIDTH'(l_in != r_in);
      OP_LT_S:  alu_res = WIDTH'($signed(l_in) <  $signed(r_in));
      OP_GE_S:  alu_res = WIDTH'($signed(l_in) >= $signed(r_in));
      OP_LT_U:  alu_res = WIDTH'(l_in <  r_in);
      OP_GE_U:  alu_res = WIDTH'(l_in >= r_in);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_DONE;
      ST_MUL: begin
        if (mul_done)      state_nxt = ST_DONE;
        else if (!mul_busy) state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (accept)         state_nxt = is_mul ? ST_MUL : ST_DONE;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 result <= '0;
    else if (accept && !is_mul) result <= alu_res;
    else if (mul_done)          result <= mul_lo;
  end

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept && is_mul),
    .a          (l_in),
    .b          (r_in),
    .busy       (mul_busy),
    .done       (mul_done),
    .product_lo (mul_lo)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=16 with hand-computed results.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] l_in, r_in, result;
  logic [4:0]  control;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] l_in16, r_in16, result16;
  logic [4:0]  control16;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .LUI_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .l_in(l_in), .r_in(r_in), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  seq_alu #(.WIDTH(16), .LUI_SHIFT(12)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .l_in(l_in16), .r_in(r_in16), .control(control16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16)
  );

  task automatic issue(input logic [31:0] l, input logic [31:0] r, input logic [4:0] op);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL issue_wait in_ready=%b required 1", in_ready);
    end
    l_in = l; r_in = r; control = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] l, input logic [15:0] r, input logic [4:0] op);
    int n = 0;
    while (!in_ready16 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready16 !== 1'b1) begin
      bad++; $display("FAIL issue16_wait in_ready=%b required 1", in_ready16);
    end
    l_in16 = l; r_in16 = r; control16 = op; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin
      bad++; $display("FAIL reset_hold in_ready=%b out_valid=%b result=%h required 0 0 0", in_ready, out_valid, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release_ready in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    issue(32'hFFFF_FFFF, 32'h1, 5'd0);
    total++;
    if (out_valid !== 1'b1 || result !== 32'h0) begin
      bad++; $display("FAIL add_wrap out_valid=%b result=%h required 1 00000000", out_valid, result);
    end
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL add_consume out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mul();
    int cyc = 1;
    int ready_seen = 0;
    issue(32'hFFFF_FFFD, 32'd7, 5'd10);
    while (!out_valid && cyc < 60) begin
      if (in_ready !== 1'b0) ready_seen++;
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc != 33) begin
      bad++; $display("FAIL mul_latency cycles=%0d required 33", cyc);
    end
    total++;
    if (result !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul_result result=%h required ffffffeb", result);
    end
    total++;
    if (ready_seen != 0) begin
      bad++; $display("FAIL mul_in_ready high_cycles=%0d required 0", ready_seen);
    end
    consume();
  endtask

  task automatic test_shifts();
    logic [31:0] la [3] = '{32'h8000_0000, 32'h8000_0000, 32'h1};
    logic [31:0] ra [3] = '{32'h24, 32'h24, 32'd31};
    logic [4:0]  oa [3] = '{5'd7, 5'd8, 5'd9};
    logic [31:0] ea [3] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(la[i], ra[i], oa[i]);
      total++;
      if (out_valid !== 1'b1 || result !== ea[i]) begin
        bad++; $display("FAIL shift_op%0d out_valid=%b result=%h required 1 %h", oa[i], out_valid, result, ea[i]);
      end
      consume();
    end
  endtask

  task automatic test_ops();
    logic [31:0] la [7] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'h8000_0000, 32'h8000_0000, 32'hFF00_FF00};
    logic [31:0] ra [7] = '{32'd7, 32'h1, 32'h1, 32'hFF00_FF00, 32'h0, 32'h0, 32'h0FF0_0FF0};
    logic [4:0]  oa [7] = '{5'd1, 5'd6, 5'd5, 5'd4, 5'd15, 5'd17, 5'd2};
    logic [31:0] ea [7] = '{32'hFFFF_FFFE, 32'h1, 32'h8000_0000, 32'h0FF0_0FF0, 32'h0, 32'h1, 32'h0F00_0F00};
    for (int i = 0; i < 7; i++) begin
      issue(la[i], ra[i], oa[i]);
      total++;
      if (out_valid !== 1'b1 || result !== ea[i]) begin
        bad++; $display("FAIL op%0d out_valid=%b result=%h required 1 %h", oa[i], out_valid, result, ea[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    issue(32'h8000_0000, 32'h0, 5'd14);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h1) drops++;
      @(posedge clk); #1;
    end
    total++;
    if (drops != 0) begin
      bad++; $display("FAIL backpressure_hold bad_cycles=%0d required 0", drops);
    end
    out_ready = 1'b1;
    l_in = 32'd5; r_in = 32'd5; control = 5'd12; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'h1) begin
      bad++; $display("FAIL b2b_eq out_valid=%b result=%h required 1 00000001", out_valid, result);
    end
    control = 5'd13;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'h0) begin
      bad++; $display("FAIL b2b_ne out_valid=%b result=%h required 1 00000000", out_valid, result);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mul();
    int spurious = 0;
    issue(32'd1, 32'd1, 5'd0);
    consume();
    issue(32'd5, 32'd6, 5'd10);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_mul_reset out_valid=%b result=%h in_ready=%b required 0 0 0", out_valid, result, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    total++;
    if (spurious != 0) begin
      bad++; $display("FAIL aborted_mul_emitted valid_cycles=%0d required 0", spurious);
    end
    issue(32'h0, 32'h000A_BCDE, 5'd11);
    total++;
    if (out_valid !== 1'b1 || result !== 32'hABCD_E000) begin
      bad++; $display("FAIL lui out_valid=%b result=%h required 1 abcde000", out_valid, result);
    end
    consume();
  endtask

  task automatic test_w16();
    logic [15:0] la [4] = '{16'h7FFF, 16'h0001, 16'h0001, 16'h1234};
    logic [15:0] ra [4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h5678};
    logic [4:0]  oa [4] = '{5'd5, 5'd17, 5'd16, 5'd25};
    logic [15:0] ea [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      issue16(la[i], ra[i], oa[i]);
      total++;
      if (out_valid16 !== 1'b1 || result16 !== ea[i]) begin
        bad++; $display("FAIL w16_op%0d out_valid=%b result=%h required 1 %h", oa[i], out_valid16, result16, ea[i]);
      end
      consume();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; l_in = '0; r_in = '0; control = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; l_in16 = '0; r_in16 = '0; control16 = '0;
    test_reset();
    test_add();
    test_mul();
    test_shifts();
    test_ops();
    test_back_to_back();
    test_reset_mul();
    test_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU.
- Generalises datapath width and completes the previously unimplemented ops: arithmetic/logical shifts, signed multiply and load-upper.
- Adds a valid/ready handshake on both input and output, and an iterative shift-add multiplier, so multiply takes multiple cycles.
- Sits between register-file read and writeback in the badge CPU execute stage.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 16 and a power of two.
- LUI_SHIFT, 12, left-shift applied to r_in for the load-upper op.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  block can accept an operation.
- l_in  in  WIDTH  left operand.
- r_in  in  WIDTH  right operand / shift amount / constant.
- control  in  5  opcode, encoded per alu_pkg.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n=0: state=IDLE, out_valid=0, result=0, in_ready=0.
  - in_ready=1 from the first clk edge after rst_n deasserts.
  - Reset mid-multiply aborts the operation; no result is emitted.
- States:
  - IDLE: in_ready=1.
  - MUL: iterating; in_ready=0.
  - DONE: out_valid=1; result held stable until out_ready.
- Accept condition: in_valid && in_ready. Operands and opcode are captured on the accept edge.
- Single-cycle ops (everything except MUL):
  - Result is registered on the accept edge; state goes to DONE.
  - out_valid is asserted the next cycle, so latency is 1.
- MUL op:
  - IDLE → MUL on accept; runs WIDTH iterations of shift-add on magnitudes; sign is applied at the end.
  - result is the low WIDTH bits of the signed product.
  - MUL → DONE after exactly WIDTH cycles, so out_valid rises WIDTH+1 cycles after accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - This allows a back-to-back accept in the same cycle a result is consumed.
  - If DONE && out_ready and no new accept occurs, the next state is IDLE and out_valid drops.
- out_valid must not drop and result must not change while out_valid && !out_ready (backpressure).
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; all wrap modulo 2^WIDTH.
  - 5 MIN_S, 6 MIN_U: return the smaller operand, signed or unsigned.
  - 7 SRA, 8 SRL, 9 SLL: the shift amount is r_in[$clog2(WIDTH)-1:0]; upper bits are ignored.
  - 10 MUL.
  - 11 LUI: result = r_in << LUI_SHIFT, zero-filled.
  - 12 EQ, 13 NE, 14 LT_S, 15 GE_S, 16 LT_U, 17 GE_U: result = {WIDTH-1 zeros, flag}.
  - 18–31: result = 0, latency 1; no error is raised.
- Signed compares use two's complement on bit WIDTH-1, e.g. the most-negative value < 0.
- in_valid while in_ready=0 is ignored; the upstream producer must hold it.

Decomposition:
- alu_pkg holds:
  - the op enum alu_op_t (5-bit, values 0–17 above);
  - the state enum alu_state_t;
  - the localparam OP_COUNT=18.
- One sub-module: seq_mul, the iterative signed multiplier.
  - Parameter: WIDTH.
  - Ports: clk, rst_n, start, a, b, busy, done, product_lo.
  - seq_alu instantiates it and holds all combinational ops inline.

Test Plan:
- ADD: reset, then accept l=0xFFFFFFFF, r=1, op=0 → out_valid next cycle, result=0x00000000; in_ready=1 in IDLE after reset.
- MUL: l=-3 (0xFFFFFFFD), r=7, op=10 → out_valid exactly 33 cycles after accept, result=0xFFFFFFEB; in_ready=0 throughout.
- Shifts: SRA l=0x80000000, r=0x24 → 0xF8000000 (amount 4, upper bits ignored); SRL same operands → 0x08000000; SLL l=1, r=31 → 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after an LT_S with l=0x80000000, r=0 → result=1 stable and out_valid held; then out_ready=1 with a new in_valid for EQ 5,5 → new op accepted the same cycle, result=1 next cycle.
- Reset mid-multiply: accept MUL, drop rst_n at cycle 10 → out_valid=0 and result=0 immediately; after release, LUI r=0xABCDE → 0xABCDE000 with latency 1.
- Defaults at WIDTH=16: op=25 → result=0x0000; GE_U l=0x0001, r=0xFFFF → 0; MIN_S l=0x7FFF, r=0x8000 → 0x8000.
